execute_stage: RTL and testbench

Execute stage of the five-stage pipelined RISC-V core. It sits directly downstream of the decode stage. It owns the ID/EX pipeline register, which captures all decode-stage control and data outputs on each rising clock edge. From the registered values it performs operand forwarding, the ALU operation, branch/jump resolution and target computation. Its outputs feed the memory stage and the fetch-stage PC mux; forwarding and flush commands come from the hazard unit.

---
 rtl/execute_stage.sv | 197 +++++++++++++++++++
 tb/tb_execute_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of the five-stage RISC-V pipeline. Owns the ID/EX pipeline
//   register and, from its contents, performs operand forwarding, the ALU
//   operation, branch/jump resolution and redirect-target computation.
//
// Ports
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   flushE              turns the instruction being captured into a bubble
//   *D                  decode-stage control/data captured into ID/EX
//   ForwardAE/BE        operand forwarding selects from the hazard unit
//   ALUResultM/ResultW  forwarded values from the memory/writeback stages
//   RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, PCPlus4E,
//   RdE, Rs1E, Rs2E     to the memory stage / hazard unit
//   PCSrcE, PCTargetE   fetch-stage redirect
//   ZeroE               ALU result equals zero
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flushE,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             JALRctrlD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] ResultW,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [4:0]       RdE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             ZeroE
);

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Forwarding select encodings; 2'b11 falls through to the register value
  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M    = 2'b10;

  // ID/EX register fields that are not directly outputs
  logic             jump_e;
  logic             branch_e;
  logic             alu_src_e;
  logic             jalr_e;
  logic [2:0]       alu_control_e;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic [WIDTH-1:0] pc_e;
  logic [WIDTH-1:0] imm_e;

  // Combinational datapath
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] jalr_sum;
  logic             slt_bit;

  // ID/EX register: reset > flush > load. No stall, the stage always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteE     <= 1'b0;
      MemWriteE     <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      jalr_e        <= 1'b0;
      ResultSrcE    <= '0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      imm_e         <= '0;
      PCPlus4E      <= '0;
      Rs1E          <= '0;
      Rs2E          <= '0;
      RdE           <= '0;
    end else if (flushE) begin
      RegWriteE     <= 1'b0;
      MemWriteE     <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      jalr_e        <= 1'b0;
      ResultSrcE    <= '0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      imm_e         <= '0;
      PCPlus4E      <= '0;
      Rs1E          <= '0;
      Rs2E          <= '0;
      RdE           <= '0;
    end else begin
      RegWriteE     <= RegWriteD;
      MemWriteE     <= MemWriteD;
      jump_e        <= JumpD;
      branch_e      <= BranchD;
      alu_src_e     <= ALUSrcD;
      jalr_e        <= JALRctrlD;
      ResultSrcE    <= ResultSrcD;
      alu_control_e <= ALUControlD;
      rd1_e         <= RD1D;
      rd2_e         <= RD2D;
      pc_e          <= PCD;
      imm_e         <= ImmExtD;
      PCPlus4E      <= PCPlus4D;
      Rs1E          <= Rs1D;
      Rs2E          <= Rs2D;
      RdE           <= RdD;
    end
  end

  // Operand forwarding. Forwarded values bypass the register, so they pass
  // through even while the register is held in reset.
  always_comb begin
    src_a = rd1_e;
    case (ForwardAE)
      FWD_RESULT_W: src_a = ResultW;
      FWD_ALU_M:    src_a = ALUResultM;
      default:      src_a = rd1_e;
    endcase
  end

  always_comb begin
    write_data = rd2_e;
    case (ForwardBE)
      FWD_RESULT_W: write_data = ResultW;
      FWD_ALU_M:    write_data = ALUResultM;
      default:      write_data = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_e : write_data;

  assign slt_bit = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_result = '0;
    case (alu_control_e)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SRL: alu_result = src_a >> src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign ALUResultE = alu_result;
  assign WriteDataE = write_data;
  assign ZeroE      = (alu_result == '0);

  // JALR targets are rs1-relative and must have bit 0 cleared; all other
  // redirects are PC-relative.
  assign jalr_sum  = src_a + imm_e;
  assign PCTargetE = jalr_e ? {jalr_sum[WIDTH-1:1], 1'b0} : (pc_e + imm_e);

  // beq is decoded as a subtract, so a taken branch is Branch & Zero.
  // A flushed bubble has Jump = Branch = 0 and can never redirect.
  assign PCSrcE = jump_e | (branch_e & ZeroE);

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flushE = 1'b0;
  logic         RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0, JALRctrlD = 0;
  logic [1:0]   ResultSrcD = 0;
  logic [2:0]   ALUControlD = 0;
  logic [W-1:0] RD1D = 0, RD2D = 0, PCD = 0, ImmExtD = 0, PCPlus4D = 0;
  logic [4:0]   Rs1D = 0, Rs2D = 0, RdD = 0;
  logic [1:0]   ForwardAE = 0, ForwardBE = 0;
  logic [W-1:0] ALUResultM = 0, ResultW = 0;

  logic         RegWriteE, MemWriteE, PCSrcE, ZeroE;
  logic [1:0]   ResultSrcE;
  logic [W-1:0] ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
  logic [4:0]   RdE, Rs1E, Rs2E;

  execute_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flushE(flushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ZeroE(ZeroE)
  );

  always #5 clk = ~clk;

  // Instruction as captured by the execute stage (model state)
  typedef struct {
    logic         rw, mw, j, b, asrc, jalr;
    logic [1:0]   rsrc;
    logic [2:0]   ctl;
    logic [W-1:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]   rs1, rs2, rd;
  } instr_t;

  instr_t m;
  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t z;
    z = '{rw:0, mw:0, j:0, b:0, asrc:0, jalr:0, rsrc:0, ctl:0,
          rd1:0, rd2:0, pc:0, imm:0, pc4:0, rs1:0, rs2:0, rd:0};
    return z;
  endfunction

  function automatic instr_t decode_now();
    instr_t d;
    d = '{rw:RegWriteD, mw:MemWriteD, j:JumpD, b:BranchD, asrc:ALUSrcD, jalr:JALRctrlD,
          rsrc:ResultSrcD, ctl:ALUControlD, rd1:RD1D, rd2:RD2D, pc:PCD, imm:ImmExtD,
          pc4:PCPlus4D, rs1:Rs1D, rs2:Rs2D, rd:RdD};
    return d;
  endfunction

  function automatic logic [W-1:0] fwd(input logic [1:0] sel, input logic [W-1:0] reg_val);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return ALUResultM;
    return reg_val;
  endfunction

  // One clock edge; the model captures what the stage should hold afterwards.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || flushE) m = bubble();
    else m = decode_now();
    #2;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] a, wd, b, alu, tgt;
    logic         zero, taken;
    a  = fwd(ForwardAE, m.rd1);
    wd = fwd(ForwardBE, m.rd2);
    b  = m.asrc ? m.imm : wd;
    case (m.ctl)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = (int'(a) < int'(b)) ? 1 : 0;
      3'd6: alu = a << (b % 32);
      default: alu = a >> (b % 32);
    endcase
    zero  = (alu == 0);
    taken = m.j || (m.b && zero);
    tgt   = m.jalr ? ((a + m.imm) & ~32'd1) : (m.pc + m.imm);
    check_val({tag, ".RegWriteE"},  W'(RegWriteE),  W'(m.rw));
    check_val({tag, ".MemWriteE"},  W'(MemWriteE),  W'(m.mw));
    check_val({tag, ".ResultSrcE"}, W'(ResultSrcE), W'(m.rsrc));
    check_val({tag, ".RdE"},        W'(RdE),        W'(m.rd));
    check_val({tag, ".Rs1E"},       W'(Rs1E),       W'(m.rs1));
    check_val({tag, ".Rs2E"},       W'(Rs2E),       W'(m.rs2));
    check_val({tag, ".PCPlus4E"},   PCPlus4E,       m.pc4);
    check_val({tag, ".WriteDataE"}, WriteDataE,     wd);
    check_val({tag, ".ALUResultE"}, ALUResultE,     alu);
    check_val({tag, ".ZeroE"},      W'(ZeroE),      W'(zero));
    check_val({tag, ".PCSrcE"},     W'(PCSrcE),     W'(taken));
    check_val({tag, ".PCTargetE"},  PCTargetE,      tgt);
  endtask

  task automatic clear_d();
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0; JALRctrlD = 0;
    ResultSrcD = 0; ALUControlD = 0; RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0;
    PCPlus4D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    ForwardAE = 0; ForwardBE = 0; flushE = 0;
  endtask

  task automatic random_d();
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom_range(0, 3) == 0);
    BranchD = 1'($urandom); ALUSrcD = 1'($urandom); JALRctrlD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RD1D = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
    RD2D = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
    PCD = $urandom; ImmExtD = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
    PCPlus4D = $urandom; Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  logic [W-1:0] sweep_exp [8];
  logic [W-1:0] fwd_exp [4];

  initial begin
    m = bubble();
    sweep_exp = '{32'h0000_0010, 32'hFFFF_FFD0, 32'h0000_0020, 32'hFFFF_FFF0,
                  32'hFFFF_FFD0, 32'h0000_0001, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    fwd_exp = '{32'd4, 32'd12, 32'd8, 32'd4};

    // Reset with live, nonzero decode inputs
    random_d();
    RdD = 5'd17; PCPlus4D = 32'hCAFE_0004; JumpD = 1; RegWriteD = 1;
    rst_n = 0;
    tick();
    tick();
    check_val("rst.RegWriteE", W'(RegWriteE), 0);
    check_val("rst.RdE", W'(RdE), 0);
    check_val("rst.PCPlus4E", PCPlus4E, 0);
    check_val("rst.ALUResultE", ALUResultE, 0);
    check_val("rst.ZeroE", W'(ZeroE), 1);
    check_val("rst.PCSrcE", W'(PCSrcE), 0);
    check_val("rst.PCTargetE", PCTargetE, 0);
    check_val("rst.WriteDataE", WriteDataE, 0);
    check_all("rst");
    rst_n = 1;
    tick();
    check_val("rst_release.RdE", W'(RdE), 17);
    check_val("rst_release.PCPlus4E", PCPlus4E, 32'hCAFE_0004);
    check_val("rst_release.PCSrcE", W'(PCSrcE), 1);
    check_all("rst_release");

    // ALU sweep
    for (int i = 0; i < 8; i++) begin
      clear_d();
      RD1D = 32'hFFFF_FFF0; RD2D = 32'h0000_0020; ALUControlD = 3'(i);
      tick();
      check_val($sformatf("alu_sweep%0d", i), ALUResultE, sweep_exp[i]);
    end

    // Forwarding of operand A
    clear_d();
    RD1D = 1; ImmExtD = 3; ALUSrcD = 1; ALUResultM = 5; ResultW = 9;
    tick();
    for (int s = 0; s < 4; s++) begin
      ForwardAE = 2'(s);
      #1;
      check_val($sformatf("fwd_a%0d", s), ALUResultE, fwd_exp[s]);
    end

    // Branch taken / not taken
    clear_d();
    BranchD = 1; ALUControlD = 3'd1; RD1D = 7; RD2D = 7; PCD = 32'h100; ImmExtD = 32'h20;
    tick();
    check_val("beq_taken.PCSrcE", W'(PCSrcE), 1);
    check_val("beq_taken.PCTargetE", PCTargetE, 32'h120);
    RD2D = 8;
    tick();
    check_val("beq_not_taken.PCSrcE", W'(PCSrcE), 0);

    // JALR
    clear_d();
    RD1D = 32'h1003; ImmExtD = 4; JumpD = 1; JALRctrlD = 1; PCPlus4D = 32'h2468;
    tick();
    check_val("jalr.PCTargetE", PCTargetE, 32'h1006);
    check_val("jalr.PCSrcE", W'(PCSrcE), 1);
    check_val("jalr.PCPlus4E", PCPlus4E, 32'h2468);

    // Flush beats a jump presented at the same edge
    clear_d();
    JumpD = 1; RegWriteD = 1; MemWriteD = 1; RdD = 5'd5; PCD = 32'h40; ImmExtD = 8;
    flushE = 1;
    tick();
    check_val("flush.RegWriteE", W'(RegWriteE), 0);
    check_val("flush.MemWriteE", W'(MemWriteE), 0);
    check_val("flush.PCSrcE", W'(PCSrcE), 0);
    check_val("flush.RdE", W'(RdE), 0);
    flushE = 0;
    tick();
    check_val("after_flush.RdE", W'(RdE), 5);
    check_val("after_flush.PCSrcE", W'(PCSrcE), 1);
    check_val("after_flush.PCTargetE", PCTargetE, 32'h48);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      random_d();
      rst_n = ($urandom_range(0, 49) != 0);
      flushE = ($urandom_range(0, 7) == 0);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ALUResultM = ($urandom_range(0, 1) == 0) ? $urandom : RD1D;
      ResultW = $urandom;
      tick();
      check_all("rand");
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ALUResultM = $urandom; ResultW = ($urandom_range(0, 1) == 0) ? $urandom : 0;
      #1;
      check_all("rand_fwd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
